dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache controller between
//  the MEM-stage load/store port and the main memory.
//  - Hits return data with no stall; misses and all stores stall the pipeline via
//    mem_stall while the main-memory handshake completes.
//  - Addresses are word addresses, consistent with the data memory word indexing.
// PARAMETERS
//  LINES   16  number of one-word cache lines (power of 2, >=2)
//  IDX_W   4   log2(LINES); index = address[IDX_W-1:0], tag = address[31:IDX_W]
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   asynchronous, active-low reset
//  address     in   32  CPU word address
//  writeData   in   32  CPU store data
//  memRead     in   1   CPU load request (level, held while stalled)
//  memWrite    in   1   CPU store request (level, held while stalled)
//  readData    out  32  load data; valid when memRead=1 and memStall=0
//  memStall    out  1   1 = hold pipeline
//  mm_addr     out  32  main-memory word address (registered)
//  mm_wdata    out  32  main-memory write data (registered)
//  mm_rd_req   out  1   main-memory read request (level)
//  mm_wr_req   out  1   main-memory write request (level)
//  mm_rdata    in   32  main-memory read data, valid when mm_rdy=1
//  mm_rdy      in   1   read data ready (1-cycle pulse)
//  mm_ack      in   1   write data accepted (1-cycle pulse)
//  hit_cnt     out  32  load-hit counter, saturates at 32'hFFFF_FFFF
//  miss_cnt    out  32  load-miss counter, saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all valid bits cleared; state=IDLE; mm_rd_req=mm_wr_req=0; mm_addr=mm_wdata=0
//   - hit_cnt=miss_cnt=0; memStall=0; readData=0. Data/tag arrays are not reset.
//  hit = valid[idx] && tag_arr[idx]==address[31:IDX_W]
//  readData = hit ? data_arr[idx] : 0 (combinational).
//  FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
//   IDLE: memWrite=1 has priority over memRead (both=1 treated as store):
//     - latch mm_addr/mm_wdata; on hit, update data_arr[idx] the same edge
//     - -> WR_WAIT
//    memRead=1 and miss:
//     - latch mm_addr, miss_cnt++ -> RD_WAIT
//    memRead=1 and hit: hit_cnt++, stay IDLE; 0 stall cycles.
//   RD_WAIT: mm_rd_req=1; on mm_rdy:
//     - write mm_rdata/tag into line, set valid -> DONE. Latency to DONE is unbounded.
//   WR_WAIT: mm_wr_req=1; on mm_ack -> DONE.
//   DONE: one cycle; memStall=0; no request sampled; readData valid from the filled line
//     -> IDLE.
//  memStall = (state==RD_WAIT||state==WR_WAIT) ||
//             (state==IDLE && (memWrite || (memRead && !hit))).
//  - Requests stay asserted until their rdy/ack pulse; rdy/ack outside the matching
//    state are ignored.
//  - Store-miss does not allocate. A store always costs >=2 stall cycles.
//  - Reset mid-RD_WAIT/WR_WAIT abandons the transaction; main memory must tolerate a
//    dropped level request.
//  - Index wrap: addresses differing only in tag conflict and evict each other.
// STRUCTURE
//  - dcache_defs package/include: state encodings, LINES/IDX_W defaults, TAG_W=32-IDX_W.
//  - One sub-module, dcache_line_array: data/tag/valid storage, combinational read port,
//    1 write port, async valid clear. FSM and counters stay in dcache_ctrl.
// TESTING
//  1 Cold read: rst pulse, memRead addr 0x10 -> memStall=1, mm_rd_req=1, mm_addr=0x10;
//    mm_rdy with 0xDEADBEEF after 3 cycles -> DONE, readData=0xDEADBEEF, miss_cnt=1.
//  2 Re-read 0x10 -> memStall=0 same cycle, readData=0xDEADBEEF, hit_cnt=1.
//  3 Store hit 0x10 = 0x12345678 -> mm_wr_req=1 until mm_ack; later read 0x10 hits
//    with 0x12345678.
//  4 Conflict: read 0x20 (idx 0, LINES=16) after 0x10 cached -> miss, fill 0xA5A5A5A5;
//    read 0x10 -> miss again.
//  5 Reset mid-op: rst low during RD_WAIT -> mm_rd_req=0 immediately, memStall=0,
//    read 0x10 misses afterwards.
//  6 memRead=memWrite=1 addr 0x30 -> store path only; miss_cnt unchanged; no mm_rd_req.

Source files
------------

// File: rtl/dcache_defs.sv
// Shared definitions for the direct-mapped, write-through data cache controller.
// Holds the controller state encoding and the default geometry (line count,
// index width, tag width) used by dcache_ctrl and dcache_line_array.
package dcache_defs;

    localparam int LINES_DEF = 16;
    localparam int IDX_W_DEF = 4;
    localparam int TAG_W_DEF = 32 - IDX_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_line_array.sv
// Storage for the one-word cache lines: data, tag and valid bit per line.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx          combinational read index
//   rd_valid/tag/data  contents of line rd_idx
//   wr_en           write line wr_idx with wr_tag/wr_data and mark it valid
//   wr_idx, wr_tag, wr_data  write port
module dcache_line_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    // Data and tag are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_arr[wr_idx] <= wr_data;
            tag_arr[wr_idx]  <= wr_tag;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller sitting
// between the MEM-stage load/store port and main memory. Addresses are word
// addresses. Load hits return data with no stall; load misses and every store
// stall the pipeline until main memory completes.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   address, writeData       CPU word address / store data
//   memRead, memWrite        CPU load / store request, held while memStall=1
//   readData                 load data (valid when memRead=1 and memStall=0)
//   memStall                 1 = hold pipeline
//   mm_addr, mm_wdata        registered main-memory address / write data
//   mm_rd_req, mm_wr_req     main-memory read / write request levels
//   mm_rdata, mm_rdy, mm_ack main-memory read data, read-ready pulse, write-ack pulse
//   hit_cnt, miss_cnt        saturating load hit / miss counters
//   dbg_state                current controller state
//
// Main-memory handshake: a request level (mm_rd_req / mm_wr_req) stays high
// from the first wait cycle until the matching one-cycle pulse (mm_rdy /
// mm_ack) is seen at a clock edge; the request drops on that edge. Pulses that
// arrive while the matching request is low are ignored.
module dcache_ctrl
    import dcache_defs::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    output logic [31:0] readData,
    output logic        memStall,
    output logic [31:0] mm_addr,
    output logic [31:0] mm_wdata,
    output logic        mm_rd_req,
    output logic        mm_wr_req,
    input  logic [31:0] mm_rdata,
    input  logic        mm_rdy,
    input  logic        mm_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output state_t      dbg_state
);

    localparam int TAG_W = 32 - IDX_W;

    state_t state, state_nxt;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;

    logic             arr_we;
    logic [IDX_W-1:0] arr_idx;
    logic [TAG_W-1:0] arr_tag;
    logic [31:0]      arr_data;

    logic latch_wr, latch_rd, hit_inc, miss_inc;

    dcache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (address[IDX_W-1:0]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (arr_we),
        .wr_idx   (arr_idx),
        .wr_tag   (arr_tag),
        .wr_data  (arr_data)
    );

    assign hit      = rd_valid && (rd_tag == address[31:IDX_W]);
    assign readData = hit ? rd_data : 32'd0;

    always_comb begin
        state_nxt = state;
        arr_we    = 1'b0;
        arr_idx   = address[IDX_W-1:0];
        arr_tag   = address[31:IDX_W];
        arr_data  = writeData;
        latch_wr  = 1'b0;
        latch_rd  = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A store wins over a simultaneous load. Store hits refresh the
                // line in place; store misses leave the cache untouched.
                if (memWrite) begin
                    latch_wr  = 1'b1;
                    arr_we    = hit;
                    state_nxt = ST_WR_WAIT;
                end else if (memRead) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        miss_inc  = 1'b1;
                        latch_rd  = 1'b1;
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Fill from the latched miss address, not the live CPU address.
                if (mm_rdy) begin
                    arr_we    = 1'b1;
                    arr_idx   = mm_addr[IDX_W-1:0];
                    arr_tag   = mm_addr[31:IDX_W];
                    arr_data  = mm_rdata;
                    state_nxt = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (mm_ack) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // Releases the pipeline for one cycle without sampling the
                // still-held request, so it is not counted twice.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            mm_addr  <= 32'd0;
            mm_wdata <= 32'd0;
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            state <= state_nxt;
            if (latch_wr) begin
                mm_addr  <= address;
                mm_wdata <= writeData;
            end else if (latch_rd) begin
                mm_addr <= address;
            end
            if (hit_inc && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_inc && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign mm_rd_req = (state == ST_RD_WAIT);
    assign mm_wr_req = (state == ST_WR_WAIT);
    // Held low while reset is asserted so the pipeline is released at once.
    assign memStall  = rst && (mm_rd_req || mm_wr_req ||
                               ((state == ST_IDLE) && (memWrite || (memRead && !hit))));
    assign dbg_state = state;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
    import dcache_defs::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address = '0, writeData = '0;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] readData, mm_addr, mm_wdata, hit_cnt, miss_cnt;
    logic        memStall, mm_rd_req, mm_wr_req;
    logic [31:0] mm_rdata = '0;
    logic        mm_rdy = 1'b0, mm_ack = 1'b0;
    state_t      dbg_state;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .writeData (writeData),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .readData  (readData),
        .memStall  (memStall),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_rd_req (mm_rd_req),
        .mm_wr_req (mm_wr_req),
        .mm_rdata  (mm_rdata),
        .mm_rdy    (mm_rdy),
        .mm_ack    (mm_ack),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- main memory responder ----------------
    logic [31:0] mem [int];
    int          rd_lat = 3, wr_lat = 2, rd_cnt = 0, wr_cnt = 0;
    bit          saw_rd = 1'b0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mm_rdy = 1'b0;
            mm_ack = 1'b0;
            if (mm_rd_req) begin
                saw_rd       = 1'b1;
                last_rd_addr = mm_addr;
                rd_cnt++;
                if (rd_cnt >= rd_lat) begin
                    mm_rdy   = 1'b1;
                    mm_rdata = mem.exists(int'(mm_addr)) ? mem[int'(mm_addr)] : 32'd0;
                    rd_cnt   = 0;
                end
            end else begin
                rd_cnt = 0;
            end
            if (mm_wr_req) begin
                last_wr_addr = mm_addr;
                wr_cnt++;
                if (wr_cnt >= wr_lat) begin
                    mm_ack              = 1'b1;
                    mem[int'(mm_addr)]  = mm_wdata;
                    wr_cnt              = 0;
                end
            end else begin
                wr_cnt = 0;
            end
        end
    end

    // ---------------- behavioural cache model ----------------
    // Tracks cache contents per line and whether a memory transaction or the
    // one-cycle completion slot is in progress.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_data  [16];
    int          m_busy  = 0;   // 0 none, 1 load fill pending, 2 store pending
    bit          m_done  = 1'b0;
    logic [31:0] m_hits = '0, m_misses = '0, m_addr = '0, m_wdata = '0;

    function automatic bit m_hit(input logic [31:0] a);
        int i;
        i = int'(a % 32'd16);
        return m_valid[i] && (m_tag[i] == a / 32'd16);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_busy = 0; m_done = 1'b0;
            m_hits = '0; m_misses = '0; m_addr = '0; m_wdata = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy == 1) begin
            if (mm_rdy) begin
                m_valid[int'(m_addr % 32'd16)] = 1'b1;
                m_tag[int'(m_addr % 32'd16)]   = m_addr / 32'd16;
                m_data[int'(m_addr % 32'd16)]  = mm_rdata;
                m_busy = 0; m_done = 1'b1;
            end
        end else if (m_busy == 2) begin
            if (mm_ack) begin
                m_busy = 0; m_done = 1'b1;
            end
        end else if (memWrite) begin
            if (m_hit(address)) m_data[int'(address % 32'd16)] = writeData;
            m_addr = address; m_wdata = writeData; m_busy = 2;
        end else if (memRead) begin
            if (m_hit(address)) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
            end else begin
                if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
                m_addr = address; m_busy = 1;
            end
        end
    end

    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        logic        e_stall;
        logic [31:0] e_rd;
        if (run_cmp) begin
            e_rd    = m_hit(address) ? m_data[int'(address % 32'd16)] : 32'd0;
            e_stall = rst && ((m_busy != 0) ||
                              (!m_done && (memWrite || (memRead && !m_hit(address)))));
            check("memStall",  32'(memStall),  32'(e_stall));
            check("readData",  readData,       e_rd);
            check("mm_rd_req", 32'(mm_rd_req), 32'(m_busy == 1));
            check("mm_wr_req", 32'(mm_wr_req), 32'(m_busy == 2));
            check("mm_addr",   mm_addr,        m_addr);
            check("mm_wdata",  mm_wdata,       m_wdata);
            check("hit_cnt",   hit_cnt,        m_hits);
            check("miss_cnt",  miss_cnt,       m_misses);
        end
    end

    // ---------------- driver tasks ----------------
    // Presents a request and returns at the negedge of the first unstalled cycle.
    task automatic cpu_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, output int stalls);
        @(posedge clk);
        #1;
        address = a; writeData = wd; memRead = rd; memWrite = wr;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!memStall) break;
            stalls++;
        end
        if (stalls >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: memStall still 1 after %0d cycles, expected release", stalls);
        end
    endtask

    task automatic cpu_idle();
        @(posedge clk);
        #1;
        memRead = 1'b0; memWrite = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        mem[32'h10] = 32'hDEAD_BEEF;
        mem[32'h20] = 32'hA5A5_A5A5;
        run_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        @(negedge clk);
        check("reset memStall", 32'(memStall), 32'd0);
        check("reset readData", readData, 32'd0);
        check("reset hit_cnt",  hit_cnt,  32'd0);
        check("reset miss_cnt", miss_cnt, 32'd0);
        check("reset mm_addr",  mm_addr,  32'd0);

        // 1: cold read, memory answers on the third wait cycle
        rd_lat = 3;
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, st);
        check("t1 stalls",    32'(st),  32'd4);
        check("t1 readData",  readData, 32'hDEAD_BEEF);
        check("t1 miss_cnt",  miss_cnt, 32'd1);
        check("t1 rd addr",   last_rd_addr, 32'h10);
        check("t1 done",      32'(dbg_state), 32'(ST_DONE));
        cpu_idle();

        // 2: re-read hits with zero stall
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, st);
        check("t2 stalls",   32'(st),  32'd0);
        check("t2 readData", readData, 32'hDEAD_BEEF);
        cpu_idle();
        check("t2 hit_cnt",  hit_cnt,  32'd1);

        // 3: store hit, then read back the updated word
        wr_lat = 2;
        cpu_op(1'b0, 1'b1, 32'h10, 32'h1234_5678, st);
        check("t3 stalls",   32'(st), 32'd3);
        check("t3 wr addr",  last_wr_addr, 32'h10);
        check("t3 mem",      mem[32'h10], 32'h1234_5678);
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, st);
        check("t3 rd stalls", 32'(st), 32'd0);
        check("t3 readData",  readData, 32'h1234_5678);
        cpu_idle();
        check("t3 hit_cnt",   hit_cnt, 32'd2);

        // 4: 0x20 and 0x10 share line 0 and evict each other
        rd_lat = 1;
        cpu_op(1'b1, 1'b0, 32'h20, 32'd0, st);
        check("t4a stalls",   32'(st), 32'd2);
        check("t4a readData", readData, 32'hA5A5_A5A5);
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, st);
        check("t4b stalls",   32'(st), 32'd2);
        check("t4b readData", readData, 32'h1234_5678);
        cpu_idle();
        check("t4 miss_cnt",  miss_cnt, 32'd3);

        // 5: reset in the middle of a fill
        rd_lat = 20;
        @(posedge clk);
        #1 address = 32'h40; memRead = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("t5 mm_rd_req", 32'(mm_rd_req), 32'd0);
        check("t5 memStall",  32'(memStall),  32'd0);
        check("t5 miss_cnt",  miss_cnt, 32'd0);
        memRead = 1'b0;
        @(posedge clk);
        #4 rst = 1'b1;
        rd_lat = 2;
        cpu_op(1'b1, 1'b0, 32'h10, 32'd0, st);
        check("t5 stalls",    32'(st), 32'd3);
        check("t5 readData",  readData, 32'h1234_5678);
        cpu_idle();
        check("t5 miss after", miss_cnt, 32'd1);
        check("t5 hit after",  hit_cnt,  32'd0);

        // 6: load+store together take the store path only
        wr_lat = 1;
        saw_rd = 1'b0;
        cpu_op(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, st);
        check("t6 stalls",   32'(st), 32'd2);
        cpu_idle();
        check("t6 miss_cnt", miss_cnt, 32'd1);
        check("t6 no rd req", 32'(saw_rd), 32'd0);
        check("t6 mem",      mem[32'h30], 32'hCAFE_F00D);
        // store miss did not allocate, so 0x30 misses and 0x10 still hits
        cpu_op(1'b1, 1'b0, 32'h30, 32'd0, st);
        check("t6 rd stalls",  32'(st), 32'd3);
        check("t6 readData",   readData, 32'hCAFE_F00D);
        cpu_idle();
        check("t6 miss after", miss_cnt, 32'd2);

        repeat (2) @(negedge clk);
        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
